// File: rtl/vga_scan_fetch.sv
// Scan-timing generator and framebuffer fetch stage for the VGA output path.
// Raw counters drive scaled framebuffer reads; coordinates are delayed to line up with the read data.
module vga_scan_fetch #(
    parameter int H_DISPLAY     = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_TOTAL       = 800,
    parameter int V_DISPLAY     = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_TOTAL       = 525,
    parameter int SCALE_SHIFT   = 1,
    parameter int READ_LATENCY  = 2,
    parameter int FB_ADDR_WIDTH = 17,
    parameter int COLORS        = 3,
    parameter int COLOR_DEPTH   = 8
) (
    input  logic                            clk_25mhz,
    input  logic                            rst,
    input  logic [FB_ADDR_WIDTH-1:0]        fb_base,
    output logic                            fb_base_ack,
    output logic                            fb_rd_en,
    output logic [FB_ADDR_WIDTH-1:0]        fb_rd_addr,
    input  logic [COLORS*COLOR_DEPTH-1:0]   fb_rd_data,
    output logic [COLORS*COLOR_DEPTH-1:0]   pixel_data,
    output logic [$clog2(H_TOTAL)-1:0]      curr_x,
    output logic [$clog2(V_TOTAL)-1:0]      curr_y,
    output logic                            frame_start,
    output logic                            vblank
);

    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);
    localparam int AW = FB_ADDR_WIDTH;

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_DISP   = XW'(H_DISPLAY);
    localparam logic [XW-1:0] X_GROUP  = XW'((1 << SCALE_SHIFT) - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_DISP   = YW'(V_DISPLAY);
    localparam logic [YW-1:0] Y_GROUP  = YW'((1 << SCALE_SHIFT) - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(H_DISPLAY >> SCALE_SHIFT);

    if (H_DISPLAY + H_FRONT + H_SYNC > H_TOTAL || V_DISPLAY + V_FRONT + V_SYNC > V_TOTAL) begin : g_bad_timing
        $error("vga_scan_fetch: display+front+sync exceeds total");
    end
    if ((H_DISPLAY % (1 << SCALE_SHIFT)) != 0) begin : g_bad_scale
        $error("vga_scan_fetch: H_DISPLAY not divisible by scale factor");
    end
    if (READ_LATENCY < 1) begin : g_bad_latency
        $error("vga_scan_fetch: READ_LATENCY must be at least 1");
    end

    logic [XW-1:0] x_raw;
    logic [YW-1:0] y_raw;
    logic [AW-1:0] col;
    logic [AW-1:0] row_base;
    logic          x_wrap;
    logic          frame_wrap;
    logic          active;

    logic [XW-1:0]           x_pipe [READ_LATENCY];
    logic [YW-1:0]           y_pipe [READ_LATENCY];
    logic [READ_LATENCY-1:0] v_pipe;
    logic [READ_LATENCY-1:0] fs_pipe;

    assign x_wrap     = (x_raw == X_LAST);
    assign frame_wrap = x_wrap && (y_raw == Y_LAST);
    assign active     = (x_raw < X_DISP) && (y_raw < Y_DISP);

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            x_raw <= '0;
            y_raw <= '0;
        end else if (x_wrap) begin
            x_raw <= '0;
            y_raw <= (y_raw == Y_LAST) ? '0 : y_raw + YW'(1);
        end else begin
            x_raw <= x_raw + XW'(1);
        end
    end

    // Address = row_base + col, both stepped incrementally so no multiplier is needed.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            col      <= '0;
            row_base <= '0;
        end else begin
            if (x_wrap) begin
                col <= '0;
            end else if ((x_raw < X_DISP) && ((x_raw & X_GROUP) == X_GROUP)) begin
                col <= col + AW'(1);
            end
            if (frame_wrap) begin
                row_base <= fb_base;
            end else if (x_wrap && (y_raw < Y_DISP) && ((y_raw & Y_GROUP) == Y_GROUP)) begin
                row_base <= row_base + ROW_STEP;
            end
        end
    end

    // Reset values park the aligned coordinates in the blank region, outside any sync pulse.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                x_pipe[i] <= X_DISP;
                y_pipe[i] <= Y_DISP;
            end
            v_pipe  <= '0;
            fs_pipe <= '0;
        end else begin
            x_pipe[0]  <= x_raw;
            y_pipe[0]  <= y_raw;
            v_pipe[0]  <= active;
            fs_pipe[0] <= (x_raw == '0) && (y_raw == '0);
            for (int i = 1; i < READ_LATENCY; i++) begin
                x_pipe[i]  <= x_pipe[i-1];
                y_pipe[i]  <= y_pipe[i-1];
                v_pipe[i]  <= v_pipe[i-1];
                fs_pipe[i] <= fs_pipe[i-1];
            end
        end
    end

    assign fb_rd_en    = active && !rst;
    assign fb_rd_addr  = row_base + col;
    assign fb_base_ack = frame_wrap;
    assign curr_x      = x_pipe[READ_LATENCY-1];
    assign curr_y      = y_pipe[READ_LATENCY-1];
    assign frame_start = fs_pipe[READ_LATENCY-1];
    assign vblank      = (curr_y >= Y_DISP);
    assign pixel_data  = v_pipe[READ_LATENCY-1] ? fb_rd_data : '0;

endmodule

// File: tb/tb_vga_scan_fetch.sv
// Bench for vga_scan_fetch using a reduced screen so whole frames fit in a short run.
// Memory model returns data = address after READ_LATENCY cycles, garbage when not read.
module tb_vga_scan_fetch;

    localparam int HD = 16, HF = 2, HS = 3, HT = 24;
    localparam int VD = 8,  VF = 1, VS = 1, VT = 12;
    localparam int SS = 1, RL = 2, AW = 8, PW = 24;
    localparam int XW = $clog2(HT);
    localparam int YW = $clog2(VT);

    logic          clk;
    logic          rst;
    logic [AW-1:0] fb_base;
    logic          fb_base_ack;
    logic          fb_rd_en;
    logic [AW-1:0] fb_rd_addr;
    logic [PW-1:0] fb_rd_data;
    logic [PW-1:0] pixel_data;
    logic [XW-1:0] curr_x;
    logic [YW-1:0] curr_y;
    logic          frame_start;
    logic          vblank;

    vga_scan_fetch #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_TOTAL(HT),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_TOTAL(VT),
        .SCALE_SHIFT(SS), .READ_LATENCY(RL), .FB_ADDR_WIDTH(AW),
        .COLORS(3), .COLOR_DEPTH(8)
    ) dut (
        .clk_25mhz(clk), .rst(rst), .fb_base(fb_base), .fb_base_ack(fb_base_ack),
        .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .pixel_data(pixel_data), .curr_x(curr_x), .curr_y(curr_y),
        .frame_start(frame_start), .vblank(vblank)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [PW-1:0] mem_pipe [RL];
    always @(posedge clk) begin
        mem_pipe[0] <= fb_rd_en ? PW'(fb_rd_addr) : 24'hABCDEF;
        for (int i = 1; i < RL; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign fb_rd_data = mem_pipe[RL-1];

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [PW-1:0] pix;
    } exp_t;

    exp_t          sb[$];
    int            mx, my;
    logic [AW-1:0] cur_base;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [AW-1:0] model_addr(input int x, input int y);
        int lin;
        lin = (y >> SS) * (HD >> SS) + (x >> SS);
        return cur_base + AW'(lin);
    endfunction

    task automatic reset_model();
        exp_t blank;
        mx = 0;
        my = 0;
        cur_base = '0;
        sb.delete();
        blank.x = XW'(HD);
        blank.y = YW'(VD);
        blank.pix = '0;
        for (int i = 0; i < RL; i++) sb.push_back(blank);
    endtask

    // Queue the aligned result for the current raw position, retire the oldest, advance one cycle.
    task automatic step();
        exp_t e;
        e.x = XW'(mx);
        e.y = YW'(my);
        e.pix = (mx < HD && my < VD) ? PW'(model_addr(mx, my)) : '0;
        sb.push_back(e);
        e = sb.pop_front();
        if (mx == HT - 1) begin
            mx = 0;
            if (my == VT - 1) begin
                my = 0;
                cur_base = fb_base;
            end else begin
                my++;
            end
        end else begin
            mx++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fb_base = '0;
        repeat (3) @(negedge clk);
        checks++; if (curr_x !== XW'(HD)) begin errors++; $display("[TB] FAIL reset_curr_x: got %0d expected %0d", curr_x, HD); end
        checks++; if (curr_y !== YW'(VD)) begin errors++; $display("[TB] FAIL reset_curr_y: got %0d expected %0d", curr_y, VD); end
        checks++; if (pixel_data !== '0) begin errors++; $display("[TB] FAIL reset_pixel: got %0h expected 0", pixel_data); end
        checks++; if (fb_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en: got %b expected 0", fb_rd_en); end
        checks++; if (fb_rd_addr !== '0) begin errors++; $display("[TB] FAIL reset_rd_addr: got %0h expected 0", fb_rd_addr); end
        checks++; if (fb_base_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0", fb_base_ack); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start: got %b expected 0", frame_start); end
        checks++; if (vblank !== 1'b1) begin errors++; $display("[TB] FAIL reset_vblank: got %b expected 1", vblank); end
        rst = 1'b0;
        #1;
        reset_model();
        checks++; if (fb_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL release_rd_en: got %b expected 1", fb_rd_en); end
        checks++; if (fb_rd_addr !== '0) begin errors++; $display("[TB] FAIL release_rd_addr: got %0h expected 0", fb_rd_addr); end
    endtask

    task automatic test_addressing();
        for (int i = 0; i < HT * VT; i++) begin
            checks++;
            if (fb_rd_en !== (mx < HD && my < VD)) begin
                errors++; $display("[TB] FAIL addr_rd_en (%0d,%0d): got %b expected %b", mx, my, fb_rd_en, (mx < HD && my < VD));
            end
            if (mx < HD && my < VD) begin
                checks++;
                if (fb_rd_addr !== model_addr(mx, my)) begin
                    errors++; $display("[TB] FAIL addr_value (%0d,%0d): got %0d expected %0d", mx, my, fb_rd_addr, model_addr(mx, my));
                end
            end
            checks++;
            if (fb_base_ack !== (mx == HT - 1 && my == VT - 1)) begin
                errors++; $display("[TB] FAIL addr_ack (%0d,%0d): got %b", mx, my, fb_base_ack);
            end
            if (mx == 0 && my == 2) begin
                checks++; if (fb_rd_addr !== 8'd8) begin errors++; $display("[TB] FAIL line2_start: got %0d expected 8", fb_rd_addr); end
            end
            if (mx == HD - 1 && my == VD - 1) begin
                checks++; if (fb_rd_addr !== 8'd31) begin errors++; $display("[TB] FAIL last_pixel_addr: got %0d expected 31", fb_rd_addr); end
            end
            step();
        end
    endtask

    task automatic test_alignment();
        int fs_cnt = 0;
        int vb_cnt = 0;
        for (int i = 0; i < HT * VT; i++) begin
            checks++;
            if (curr_x !== sb[0].x || curr_y !== sb[0].y) begin
                errors++; $display("[TB] FAIL align_xy cycle %0d: got (%0d,%0d) expected (%0d,%0d)", i, curr_x, curr_y, sb[0].x, sb[0].y);
            end
            checks++;
            if (pixel_data !== sb[0].pix) begin
                errors++; $display("[TB] FAIL align_pixel (%0d,%0d): got %0h expected %0h", sb[0].x, sb[0].y, pixel_data, sb[0].pix);
            end
            checks++;
            if (frame_start !== (sb[0].x == '0 && sb[0].y == '0)) begin
                errors++; $display("[TB] FAIL align_frame_start (%0d,%0d): got %b", sb[0].x, sb[0].y, frame_start);
            end
            checks++;
            if (vblank !== (sb[0].y >= YW'(VD))) begin
                errors++; $display("[TB] FAIL align_vblank y=%0d: got %b", sb[0].y, vblank);
            end
            if (frame_start === 1'b1) fs_cnt++;
            if (vblank === 1'b1) vb_cnt++;
            step();
        end
        checks++; if (fs_cnt != 1) begin errors++; $display("[TB] FAIL frame_start_count: got %0d expected 1", fs_cnt); end
        checks++; if (vb_cnt != (VT - VD) * HT) begin errors++; $display("[TB] FAIL vblank_count: got %0d expected %0d", vb_cnt, (VT - VD) * HT); end
    endtask

    task automatic test_base_swap();
        int guard = 0;
        int acks = 0;
        while (!(mx == 5 && my == 3) && guard < HT * VT) begin step(); guard++; end
        checks++; if (!(mx == 5 && my == 3)) begin errors++; $display("[TB] FAIL swap_reach_timeout: got (%0d,%0d) expected (5,3)", mx, my); end
        fb_base = 8'hF0;
        guard = 0;
        do begin
            if (mx < HD && my < VD) begin
                checks++;
                if (fb_rd_addr !== model_addr(mx, my)) begin
                    errors++; $display("[TB] FAIL swap_old_addr (%0d,%0d): got %0h expected %0h", mx, my, fb_rd_addr, model_addr(mx, my));
                end
            end
            checks++;
            if (fb_base_ack !== (mx == HT - 1 && my == VT - 1)) begin
                errors++; $display("[TB] FAIL swap_ack (%0d,%0d): got %b", mx, my, fb_base_ack);
            end
            if (fb_base_ack === 1'b1) acks++;
            step();
            guard++;
        end while (!(mx == 0 && my == 0) && guard < HT * VT);
        checks++; if (acks != 1) begin errors++; $display("[TB] FAIL swap_ack_count: got %0d expected 1", acks); end
        checks++; if (fb_rd_addr !== 8'hF0) begin errors++; $display("[TB] FAIL swap_new_first: got %0h expected f0", fb_rd_addr); end
        fb_base = 8'h20;
        for (int i = 0; i < HT * VT; i++) begin
            if (mx < HD && my < VD) begin
                checks++;
                if (fb_rd_addr !== model_addr(mx, my)) begin
                    errors++; $display("[TB] FAIL swap_new_addr (%0d,%0d): got %0h expected %0h", mx, my, fb_rd_addr, model_addr(mx, my));
                end
            end
            if (mx == HD - 1 && my == VD - 1) begin
                checks++; if (fb_rd_addr !== 8'h0F) begin errors++; $display("[TB] FAIL swap_wrap_addr: got %0h expected 0f", fb_rd_addr); end
            end
            checks++;
            if (pixel_data !== sb[0].pix) begin
                errors++; $display("[TB] FAIL swap_pixel (%0d,%0d): got %0h expected %0h", sb[0].x, sb[0].y, pixel_data, sb[0].pix);
            end
            step();
        end
    endtask

    task automatic test_midframe_reset();
        int guard = 0;
        while (!(mx == 10 && my == 5) && guard < HT * VT) begin step(); guard++; end
        checks++; if (!(mx == 10 && my == 5)) begin errors++; $display("[TB] FAIL mid_reach_timeout: got (%0d,%0d) expected (10,5)", mx, my); end
        #2 rst = 1'b1;
        #1;
        checks++; if (curr_x !== XW'(HD) || curr_y !== YW'(VD)) begin errors++; $display("[TB] FAIL mid_async_xy: got (%0d,%0d) expected (%0d,%0d)", curr_x, curr_y, HD, VD); end
        checks++; if (pixel_data !== '0) begin errors++; $display("[TB] FAIL mid_async_pixel: got %0h expected 0", pixel_data); end
        checks++; if (fb_rd_en !== 1'b0 || fb_rd_addr !== '0) begin errors++; $display("[TB] FAIL mid_async_fetch: got en=%b addr=%0h expected en=0 addr=0", fb_rd_en, fb_rd_addr); end
        checks++; if (vblank !== 1'b1 || frame_start !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_flags: got vblank=%b fs=%b expected 1,0", vblank, frame_start); end
        @(negedge clk);
        fb_base = 8'h55;
        @(negedge clk);
        rst = 1'b0;
        #1;
        reset_model();
        checks++; if (fb_rd_en !== 1'b1 || fb_rd_addr !== '0) begin errors++; $display("[TB] FAIL mid_release_fetch: got en=%b addr=%0h expected en=1 addr=0", fb_rd_en, fb_rd_addr); end
        for (int i = 0; i < 2 * HT; i++) begin
            checks++;
            if (curr_x !== sb[0].x || curr_y !== sb[0].y || pixel_data !== sb[0].pix) begin
                errors++; $display("[TB] FAIL mid_align cycle %0d: got (%0d,%0d,%0h) expected (%0d,%0d,%0h)", i, curr_x, curr_y, pixel_data, sb[0].x, sb[0].y, sb[0].pix);
            end
            if (mx < HD && my < VD) begin
                checks++;
                if (fb_rd_addr !== model_addr(mx, my)) begin
                    errors++; $display("[TB] FAIL mid_addr (%0d,%0d): got %0h expected %0h", mx, my, fb_rd_addr, model_addr(mx, my));
                end
            end
            if (i == RL) begin
                checks++; if (curr_x !== '0 || curr_y !== '0 || pixel_data !== '0) begin errors++; $display("[TB] FAIL mid_first_pixel: got (%0d,%0d,%0h) expected (0,0,0)", curr_x, curr_y, pixel_data); end
            end
            if (i == RL + 2) begin
                checks++; if (pixel_data !== 24'd1) begin errors++; $display("[TB] FAIL mid_third_pixel: got %0h expected 1", pixel_data); end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_addressing();
        test_alignment();
        test_base_swap();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
